// File: rtl/rv_ctrl_pipe.sv
// rv_ctrl_pipe: pipelined control path for the 5-stage RISC-V core.
// Decodes the ID opcode into a control bundle and carries it through the
// ID/EX, EX/MEM and MEM/WB registers. Also handles load-use stalls,
// redirect flushes, EX forwarding selects and saturating event counters.
module rv_ctrl_pipe #(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter bit HAZARD_EN = 1'b1,
  parameter bit FWD_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  output logic [2:0]        id_immsrc,
  output logic              id_illegal,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              ex_valid,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_alusrc,
  output logic [1:0]        ex_aluop,
  output logic [1:0]        ex_asel,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              mem_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [1:0]        wb_sel,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Raw decode table fields (before qualification by id_valid/legal)
  logic       d_legal, d_regwrite, d_memread, d_memwrite, d_alusrc;
  logic       d_branch, d_jump, d_use_rs1, d_use_rs2;
  logic [1:0] d_aluop, d_asel, d_wbsel;
  logic [2:0] d_immsrc;

  // Qualified bundle entering ID/EX
  logic       dec_ok, q_regwrite, use_rs1, use_rs2;
  logic       stall, bubble;

  // Additional pipeline state not exposed on ports
  logic              ex_memread, ex_memwrite, ex_regwrite;
  logic [1:0]        ex_wbsel;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              mem_regwrite;
  logic [1:0]        mem_wbsel;
  logic [REG_AW-1:0] mem_rd;

  // Opcode decode table; unknown opcodes leave d_legal low
  always_comb begin
    d_legal = 1'b0; d_regwrite = 1'b0; d_memread = 1'b0; d_memwrite = 1'b0;
    d_alusrc = 1'b0; d_branch = 1'b0; d_jump = 1'b0;
    d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
    d_aluop = 2'b00; d_asel = 2'b00; d_wbsel = 2'b00; d_immsrc = 3'b000;
    case (id_opcode)
      OP_LOAD:   begin d_legal = 1'b1; d_regwrite = 1'b1; d_memread = 1'b1; d_alusrc = 1'b1;
                       d_wbsel = 2'b01; d_immsrc = 3'b000; d_use_rs1 = 1'b1; end
      OP_STORE:  begin d_legal = 1'b1; d_memwrite = 1'b1; d_alusrc = 1'b1; d_immsrc = 3'b001;
                       d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; end
      OP_R:      begin d_legal = 1'b1; d_regwrite = 1'b1; d_aluop = 2'b10;
                       d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; end
      OP_IALU:   begin d_legal = 1'b1; d_regwrite = 1'b1; d_alusrc = 1'b1; d_aluop = 2'b10;
                       d_immsrc = 3'b000; d_use_rs1 = 1'b1; end
      OP_BRANCH: begin d_legal = 1'b1; d_branch = 1'b1; d_aluop = 2'b01; d_immsrc = 3'b010;
                       d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; end
      OP_JAL:    begin d_legal = 1'b1; d_regwrite = 1'b1; d_jump = 1'b1; d_asel = 2'b01;
                       d_alusrc = 1'b1; d_wbsel = 2'b10; d_immsrc = 3'b011; end
      OP_JALR:   begin d_legal = 1'b1; d_regwrite = 1'b1; d_jump = 1'b1; d_alusrc = 1'b1;
                       d_wbsel = 2'b10; d_immsrc = 3'b000; d_use_rs1 = 1'b1; end
      OP_LUI:    begin d_legal = 1'b1; d_regwrite = 1'b1; d_asel = 2'b10; d_alusrc = 1'b1;
                       d_immsrc = 3'b100; end
      OP_AUIPC:  begin d_legal = 1'b1; d_regwrite = 1'b1; d_asel = 2'b01; d_alusrc = 1'b1;
                       d_immsrc = 3'b100; end
      default:   d_legal = 1'b0;
    endcase
  end

  assign dec_ok     = id_valid & d_legal;
  assign id_illegal = id_valid & ~d_legal;
  assign id_immsrc  = dec_ok ? d_immsrc : 3'b000;
  assign q_regwrite = dec_ok & d_regwrite & (id_rd != '0);
  assign use_rs1    = dec_ok & d_use_rs1;
  assign use_rs2    = dec_ok & d_use_rs2;

  // Load-use detection; a redirect in the same cycle wins and suppresses it
  always_comb begin
    stall = 1'b0;
    if (HAZARD_EN && ex_valid && ex_memread && (ex_rd != '0) &&
        ((use_rs1 && (ex_rd == id_rs1)) || (use_rs2 && (ex_rd == id_rs2))))
      stall = 1'b1;
    if (ex_redirect)
      stall = 1'b0;
  end

  assign bubble     = stall | ex_redirect;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign ifid_flush = ex_redirect;

  // ID/EX register: loads the qualified bundle, or an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0; ex_branch <= 1'b0; ex_jump <= 1'b0; ex_alusrc <= 1'b0;
      ex_aluop <= 2'b00; ex_asel <= 2'b00; ex_memread <= 1'b0; ex_memwrite <= 1'b0;
      ex_regwrite <= 1'b0; ex_wbsel <= 2'b00;
      ex_rs1 <= '0; ex_rs2 <= '0; ex_rd <= '0;
    end else if (bubble || !dec_ok) begin
      ex_valid <= 1'b0; ex_branch <= 1'b0; ex_jump <= 1'b0; ex_alusrc <= 1'b0;
      ex_aluop <= 2'b00; ex_asel <= 2'b00; ex_memread <= 1'b0; ex_memwrite <= 1'b0;
      ex_regwrite <= 1'b0; ex_wbsel <= 2'b00;
      ex_rs1 <= '0; ex_rs2 <= '0; ex_rd <= '0;
    end else begin
      ex_valid <= 1'b1; ex_branch <= d_branch; ex_jump <= d_jump; ex_alusrc <= d_alusrc;
      ex_aluop <= d_aluop; ex_asel <= d_asel; ex_memread <= d_memread;
      ex_memwrite <= d_memwrite; ex_regwrite <= q_regwrite; ex_wbsel <= d_wbsel;
      ex_rs1 <= id_rs1; ex_rs2 <= id_rs2; ex_rd <= id_rd;
    end
  end

  // EX/MEM and MEM/WB registers always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid <= 1'b0; mem_read <= 1'b0; mem_write <= 1'b0;
      mem_regwrite <= 1'b0; mem_wbsel <= 2'b00; mem_rd <= '0;
      wb_valid <= 1'b0; wb_regwrite <= 1'b0; wb_sel <= 2'b00; wb_rd <= '0;
    end else begin
      mem_valid <= ex_valid; mem_read <= ex_memread; mem_write <= ex_memwrite;
      mem_regwrite <= ex_regwrite; mem_wbsel <= ex_wbsel; mem_rd <= ex_rd;
      wb_valid <= mem_valid; wb_regwrite <= mem_regwrite; wb_sel <= mem_wbsel; wb_rd <= mem_rd;
    end
  end

  // EX operand forwarding: EX/MEM result takes priority over MEM/WB
  always_comb begin
    ex_fwd_a = 2'b00;
    ex_fwd_b = 2'b00;
    if (FWD_EN) begin
      if (mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1))
        ex_fwd_a = 2'b10;
      else if (wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1))
        ex_fwd_a = 2'b01;
      if (mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2))
        ex_fwd_b = 2'b10;
      else if (wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2))
        ex_fwd_b = 2'b01;
    end
  end

  // Saturating event counters, held at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0; flush_cnt <= '0; illegal_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))         stall_cnt   <= stall_cnt + CNT_W'(1);
      if (ex_redirect && (flush_cnt != '1))   flush_cnt   <= flush_cnt + CNT_W'(1);
      if (id_illegal && (illegal_cnt != '1))  illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// tb_rv_ctrl_pipe: directed scenarios for rv_ctrl_pipe. A second instance
// with 2-bit counters shares the stimulus to exercise counter saturation.
module tb_rv_ctrl_pipe;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = 7'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       ex_redirect = 1'b0;

  logic [2:0]  id_immsrc;
  logic        id_illegal, pc_write, ifid_write, ifid_flush;
  logic        ex_valid, ex_branch, ex_jump, ex_alusrc;
  logic [1:0]  ex_aluop, ex_asel, ex_fwd_a, ex_fwd_b;
  logic        mem_valid, mem_read, mem_write, wb_valid, wb_regwrite;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic [15:0] stall_cnt, flush_cnt, illegal_cnt;

  logic [2:0]  s_immsrc;
  logic        s_illegal, s_pc_write, s_ifid_write, s_ifid_flush;
  logic        s_ex_valid, s_ex_branch, s_ex_jump, s_ex_alusrc;
  logic [1:0]  s_ex_aluop, s_ex_asel, s_fwd_a, s_fwd_b;
  logic        s_mem_valid, s_mem_read, s_mem_write, s_wb_valid, s_wb_regwrite;
  logic [1:0]  s_wb_sel;
  logic [4:0]  s_wb_rd;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_illegal_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .id_immsrc(id_immsrc), .id_illegal(id_illegal), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alusrc(ex_alusrc),
    .ex_aluop(ex_aluop), .ex_asel(ex_asel), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_sel(wb_sel), .wb_rd(wb_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .illegal_cnt(illegal_cnt)
  );

  rv_ctrl_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .id_immsrc(s_immsrc), .id_illegal(s_illegal), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .ex_valid(s_ex_valid),
    .ex_branch(s_ex_branch), .ex_jump(s_ex_jump), .ex_alusrc(s_ex_alusrc),
    .ex_aluop(s_ex_aluop), .ex_asel(s_ex_asel), .ex_fwd_a(s_fwd_a), .ex_fwd_b(s_fwd_b),
    .mem_valid(s_mem_valid), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .wb_valid(s_wb_valid), .wb_regwrite(s_wb_regwrite), .wb_sel(s_wb_sel), .wb_rd(s_wb_rd),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .illegal_cnt(s_illegal_cnt)
  );

  task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic redir);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_redirect = redir;
  endtask

  task automatic set_idle();
    set_id(1'b0, 7'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Leaves the bench at a falling edge with reset released
  task automatic apply_reset();
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL por_ex_valid got %0h want 0", ex_valid); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("[TB] FAIL por_wb_rd got %0h want 0", wb_rd); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL por_stall_cnt got %0h want 0", stall_cnt); end
    checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL por_pc_write got %0h want 1", pc_write); end
    apply_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    @(negedge clk);
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
    @(negedge clk);
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
    @(negedge clk);
    set_id(1'b1, OP_LW, 5'd2, 5'd0, 5'd7, 1'b0);
    @(negedge clk);
    set_id(1'b1, OP_R, 5'd7, 5'd0, 5'd8, 1'b0);
    #1;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_prestall_pc_write got %0h want 0", pc_write); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rst_pre_stall_cnt got %0h want 1", stall_cnt); end
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_mem_valid got %0h want 1", mem_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_ex_valid got %0h want 0", ex_valid); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_mem_valid got %0h want 0", mem_valid); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_async_stall_cnt got %0h want 0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_pc_write got %0h want 1", pc_write); end
    set_idle();
  endtask

  task automatic test_load_use();
    apply_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    #1;
    checks++; if (id_immsrc !== 3'b000) begin errors++; $display("[TB] FAIL lw_immsrc got %0h want 0", id_immsrc); end
    checks++; if (id_illegal !== 1'b0) begin errors++; $display("[TB] FAIL lw_illegal got %0h want 0", id_illegal); end
    @(negedge clk);
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL lw_ex_valid got %0h want 1", ex_valid); end
    checks++; if (ex_alusrc !== 1'b1) begin errors++; $display("[TB] FAIL lw_ex_alusrc got %0h want 1", ex_alusrc); end
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
    #1;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL lu_pc_write got %0h want 0", pc_write); end
    checks++; if (ifid_write !== 1'b0) begin errors++; $display("[TB] FAIL lu_ifid_write got %0h want 0", ifid_write); end
    @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble_ex_valid got %0h want 0", ex_valid); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL lu_mem_read got %0h want 1", mem_read); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL lu_stall_cnt got %0h want 1", stall_cnt); end
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL lu_resume_pc_write got %0h want 1", pc_write); end
    @(negedge clk);
    set_idle();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL lu_add_ex_valid got %0h want 1", ex_valid); end
    checks++; if (ex_aluop !== 2'b10) begin errors++; $display("[TB] FAIL lu_add_aluop got %0h want 2", ex_aluop); end
    checks++; if (ex_fwd_a !== 2'b01) begin errors++; $display("[TB] FAIL lu_fwd_a got %0h want 1", ex_fwd_a); end
    checks++; if (ex_fwd_b !== 2'b00) begin errors++; $display("[TB] FAIL lu_fwd_b got %0h want 0", ex_fwd_b); end
    checks++; if (wb_sel !== 2'b01) begin errors++; $display("[TB] FAIL lu_wb_sel got %0h want 1", wb_sel); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL lu_stall_cnt_hold got %0h want 1", stall_cnt); end
  endtask

  task automatic test_alu_forwarding();
    apply_reset();
    set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
    @(negedge clk);
    set_id(1'b1, OP_IALU, 5'd3, 5'd0, 5'd3, 1'b0);
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL alu_no_stall got %0h want 1", pc_write); end
    @(negedge clk);
    checks++; if (ex_fwd_a !== 2'b10) begin errors++; $display("[TB] FAIL addi_fwd_a got %0h want 2", ex_fwd_a); end
    checks++; if (ex_fwd_b !== 2'b00) begin errors++; $display("[TB] FAIL addi_fwd_b got %0h want 0", ex_fwd_b); end
    set_id(1'b1, OP_R, 5'd3, 5'd3, 5'd4, 1'b0);
    @(negedge clk);
    checks++; if (ex_fwd_a !== 2'b10) begin errors++; $display("[TB] FAIL sub_fwd_a got %0h want 2", ex_fwd_a); end
    checks++; if (ex_fwd_b !== 2'b10) begin errors++; $display("[TB] FAIL sub_fwd_b got %0h want 2", ex_fwd_b); end
    checks++; if (wb_rd !== 5'd3) begin errors++; $display("[TB] FAIL add_wb_rd got %0h want 3", wb_rd); end
    checks++; if (wb_regwrite !== 1'b1) begin errors++; $display("[TB] FAIL add_wb_regwrite got %0h want 1", wb_regwrite); end
    checks++; if (wb_sel !== 2'b00) begin errors++; $display("[TB] FAIL add_wb_sel got %0h want 0", wb_sel); end
    set_idle();
    @(negedge clk);
    set_id(1'b1, OP_R, 5'd0, 5'd4, 5'd7, 1'b0);
    @(negedge clk);
    set_idle();
    checks++; if (ex_fwd_b !== 2'b01) begin errors++; $display("[TB] FAIL wb_fwd_b got %0h want 1", ex_fwd_b); end
    checks++; if (ex_fwd_a !== 2'b00) begin errors++; $display("[TB] FAIL x0_fwd_a got %0h want 0", ex_fwd_a); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL alu_stall_cnt got %0h want 0", stall_cnt); end
  endtask

  task automatic test_flush_over_stall();
    apply_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd7, 1'b0);
    @(negedge clk);
    set_id(1'b1, OP_R, 5'd7, 5'd0, 5'd8, 1'b1);
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL fl_pc_write got %0h want 1", pc_write); end
    checks++; if (ifid_write !== 1'b1) begin errors++; $display("[TB] FAIL fl_ifid_write got %0h want 1", ifid_write); end
    checks++; if (ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL fl_ifid_flush got %0h want 1", ifid_flush); end
    @(negedge clk);
    set_idle();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_bubble got %0h want 0", ex_valid); end
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL fl_load_advanced got %0h want 1", mem_valid); end
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("[TB] FAIL fl_flush_cnt got %0h want 1", flush_cnt); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL fl_stall_cnt got %0h want 0", stall_cnt); end
    #1;
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("[TB] FAIL fl_flush_drop got %0h want 0", ifid_flush); end
  endtask

  task automatic test_store_and_lui();
    apply_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    @(negedge clk);
    set_id(1'b1, OP_LUI, 5'd5, 5'd5, 5'd6, 1'b0);
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL lui_no_stall got %0h want 1", pc_write); end
    checks++; if (id_immsrc !== 3'b100) begin errors++; $display("[TB] FAIL lui_immsrc got %0h want 4", id_immsrc); end
    @(negedge clk);
    checks++; if (ex_asel !== 2'b10) begin errors++; $display("[TB] FAIL lui_asel got %0h want 2", ex_asel); end
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    @(negedge clk);
    set_id(1'b1, OP_SW, 5'd2, 5'd5, 5'd0, 1'b0);
    #1;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL sw_rs2_stall got %0h want 1'b0", pc_write); end
    checks++; if (id_immsrc !== 3'b001) begin errors++; $display("[TB] FAIL sw_immsrc got %0h want 1", id_immsrc); end
    @(negedge clk);
    @(negedge clk);
    set_idle();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL sw_ex_valid got %0h want 1", ex_valid); end
    @(negedge clk);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("[TB] FAIL sw_mem_write got %0h want 1", mem_write); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL sw_stall_cnt got %0h want 1", stall_cnt); end
  endtask

  task automatic test_illegal();
    apply_reset();
    set_id(1'b0, OP_BAD, 5'd0, 5'd0, 5'd9, 1'b0);
    #1;
    checks++; if (id_illegal !== 1'b0) begin errors++; $display("[TB] FAIL ill_invalid got %0h want 0", id_illegal); end
    set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd9, 1'b0);
    @(negedge clk);
    set_id(1'b1, OP_BAD, 5'd0, 5'd0, 5'd9, 1'b0);
    #1;
    checks++; if (id_illegal !== 1'b1) begin errors++; $display("[TB] FAIL ill_flag got %0h want 1", id_illegal); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (wb_regwrite !== 1'b1) begin errors++; $display("[TB] FAIL ill_prev_wb_regwrite got %0h want 1", wb_regwrite); end
    @(negedge clk);
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL ill_wb_regwrite got %0h want 0", wb_regwrite); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL ill_wb_valid got %0h want 0", wb_valid); end
    checks++; if (s_illegal_cnt !== 2'd3) begin errors++; $display("[TB] FAIL ill_sat_cnt3 got %0h want 3", s_illegal_cnt); end
    @(negedge clk);
    @(negedge clk);
    set_idle();
    checks++; if (illegal_cnt !== 16'd5) begin errors++; $display("[TB] FAIL ill_cnt got %0h want 5", illegal_cnt); end
    checks++; if (s_illegal_cnt !== 2'd3) begin errors++; $display("[TB] FAIL ill_sat_hold got %0h want 3", s_illegal_cnt); end
  endtask

  task automatic test_jal();
    apply_reset();
    set_id(1'b1, OP_JAL, 5'd3, 5'd4, 5'd1, 1'b0);
    #1;
    checks++; if (id_immsrc !== 3'b011) begin errors++; $display("[TB] FAIL jal_immsrc got %0h want 3", id_immsrc); end
    @(negedge clk);
    checks++; if (ex_asel !== 2'b01) begin errors++; $display("[TB] FAIL jal_asel got %0h want 1", ex_asel); end
    checks++; if (ex_jump !== 1'b1) begin errors++; $display("[TB] FAIL jal_jump got %0h want 1", ex_jump); end
    checks++; if (ex_branch !== 1'b0) begin errors++; $display("[TB] FAIL jal_branch got %0h want 0", ex_branch); end
    set_id(1'b1, OP_JAL, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    checks++; if (wb_sel !== 2'b10) begin errors++; $display("[TB] FAIL jal_wb_sel got %0h want 2", wb_sel); end
    checks++; if (wb_regwrite !== 1'b1) begin errors++; $display("[TB] FAIL jal_wb_regwrite got %0h want 1", wb_regwrite); end
    checks++; if (wb_rd !== 5'd1) begin errors++; $display("[TB] FAIL jal_wb_rd got %0h want 1", wb_rd); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL jalx0_wb_valid got %0h want 1", wb_valid); end
    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL jalx0_wb_regwrite got %0h want 0", wb_regwrite); end
  endtask

  initial begin
    $display("[TB] starting rv_ctrl_pipe directed tests");
    test_reset();
    test_load_use();
    test_alu_forwarding();
    test_flush_over_stall();
    test_store_and_lui();
    test_illegal();
    test_jal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
